// File: rtl/stack_cpu_pkg.sv
// Shared constants and types for the stack CPU slice.
// Holds the opcode set and the fetch FSM state encoding.
package stack_cpu_pkg;

   localparam int FETCH_ADDR_W     = 2;
   localparam int FETCH_DATA_W     = 8;
   localparam int FETCH_PRESCALE_W = 23;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_NOP1    = 8'h01;
   localparam logic [7:0] OP_LED_OFF = 8'h02;
   localparam logic [7:0] OP_LED_ON  = 8'h03;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// ROM port, instruction handshake and redirect/halt controls
// between the fetch unit (master) and its ROM/executor (slave).
interface fetch_unit_if
   import stack_cpu_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W
);

   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              jump_valid;
   logic [ADDR_W-1:0] jump_addr;
   logic              halt;

   modport master (
      output rom_en, rom_addr,
      input  rom_data,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready,
      input  jump_valid, jump_addr, halt
   );

   modport slave (
      input  rom_en, rom_addr,
      output rom_data,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready,
      output jump_valid, jump_addr, halt
   );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler; tick is high for the one cycle
// in which the counter is all-ones.
module tick_gen #(
   parameter int PRESCALE_W = 23
) (
   input  logic CLK,
   input  logic RST_N,
   output logic tick
);

   logic [PRESCALE_W-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt <= '0;
      else        cnt <= cnt + 1'b1;
   end

   assign tick = &cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE -> READ -> HOLD against a sync ROM.
// Define FETCH_PRESCALE_EN to pace fetches with tick_gen.
module fetch_unit
   import stack_cpu_pkg::*;
#(
   parameter int ADDR_W     = FETCH_ADDR_W,
   parameter int DATA_W     = FETCH_DATA_W,
   parameter int PRESCALE_W = FETCH_PRESCALE_W
) (
   input logic          CLK,
   input logic          RST_N,
   fetch_unit_if.master bus
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] instr_pc_q;
   logic [DATA_W-1:0] instr_data_q;
   logic              instr_valid_q;
   logic              tick;
   logic              issue;

`ifdef FETCH_PRESCALE_EN
   tick_gen #(
      .PRESCALE_W(PRESCALE_W)
   ) u_tick_gen (
      .CLK  (CLK),
      .RST_N(RST_N),
      .tick (tick)
   );
`else
   assign tick = (PRESCALE_W > 0);
`endif

   // A pending jump always wins over a new fetch.
   assign issue = (state == IDLE) & tick
                & ~bus.halt & ~bus.jump_valid;

   assign bus.rom_en      = issue;
   assign bus.rom_addr    = pc;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_data  = instr_data_q;
   assign bus.instr_pc    = instr_pc_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         pc            <= '0;
         fetch_addr    <= '0;
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         instr_pc_q    <= '0;
      end else if (bus.jump_valid) begin
         pc            <= bus.jump_addr;
         state         <= IDLE;
         instr_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue) begin
                  pc         <= pc + 1'b1;
                  fetch_addr <= pc;
                  state      <= READ;
               end
            end
            READ: begin
               instr_data_q  <= bus.rom_data;
               instr_pc_q    <= fetch_addr;
               instr_valid_q <= 1'b1;
               state         <= HOLD;
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  instr_valid_q <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit; scenario set depends on
// whether FETCH_PRESCALE_EN is defined.
module tb_fetch_unit;
   import stack_cpu_pkg::*;

`ifdef FETCH_PRESCALE_EN
   localparam int PW = 4;
`else
   localparam int PW = FETCH_PRESCALE_W;
`endif

   typedef struct {
      logic [1:0] pc;
      logic [7:0] data;
   } exp_t;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   int   pass_cnt = 0;
   int   total    = 0;
   exp_t sb[$];
   logic [7:0] rom [4];

   always #5 CLK = ~CLK;

   fetch_unit_if bus ();

   fetch_unit #(
      .PRESCALE_W(PW)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   always @(posedge CLK)
      if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

   task automatic apply_reset(input bit rdy);
      bus.instr_ready = rdy;
      bus.halt        = 1'b0;
      bus.jump_valid  = 1'b0;
      bus.jump_addr   = 2'd0;
      RST_N           = 1'b0;
      sb.delete();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      int c;
      c  = 0;
      ok = bus.instr_valid;
      while (!ok && c < max) begin
         @(negedge CLK);
         c++;
         ok = bus.instr_valid;
      end
   endtask

   task automatic wait_rom_en(input int max, output bit ok);
      int c;
      c  = 0;
      ok = bus.rom_en;
      while (!ok && c < max) begin
         @(negedge CLK);
         c++;
         ok = bus.rom_en;
      end
   endtask

   task automatic test_reset;
      bus.instr_ready = 1'b1;
      bus.halt        = 1'b0;
      bus.jump_valid  = 1'b0;
      bus.jump_addr   = 2'd0;
      RST_N           = 1'b0;
      @(negedge CLK);
      total++;
      if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid);
      else pass_cnt++;
      total++;
      if (bus.instr_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.instr_data);
      else pass_cnt++;
      total++;
      if (bus.instr_pc !== 2'd0) $display("FAIL reset_pc: got %0d want 0", bus.instr_pc);
      else pass_cnt++;
      total++;
      if (bus.rom_addr !== 2'd0) $display("FAIL reset_addr: got %0d want 0", bus.rom_addr);
      else pass_cnt++;
`ifdef FETCH_PRESCALE_EN
      total++;
      if (bus.rom_en !== 1'b0) $display("FAIL reset_rom_en: got %b want 0", bus.rom_en);
      else pass_cnt++;
`endif
   endtask

   task automatic test_stream;
      int   c, last, got;
      exp_t e;
      apply_reset(1'b1);
      sb.push_back('{2'd0, OP_NOP});
      sb.push_back('{2'd1, OP_LED_OFF});
      sb.push_back('{2'd2, OP_NOP1});
      sb.push_back('{2'd3, OP_LED_ON});
      sb.push_back('{2'd0, OP_NOP});
      c = 0; last = -1; got = 0;
      while (got < 5 && c < 40) begin
         @(negedge CLK);
         c++;
         if (bus.instr_valid && bus.instr_ready) begin
            e = sb.pop_front();
            total++;
            if (bus.instr_pc !== e.pc) $display("FAIL stream_pc: got %0d want %0d", bus.instr_pc, e.pc);
            else pass_cnt++;
            total++;
            if (bus.instr_data !== e.data) $display("FAIL stream_data: got %h want %h", bus.instr_data, e.data);
            else pass_cnt++;
            total++;
            if (last < 0 && c !== 2) $display("FAIL stream_latency: got %0d want 2", c);
            else if (last >= 0 && c - last !== 3) $display("FAIL stream_spacing: got %0d want 3", c - last);
            else pass_cnt++;
            last = c;
            got++;
         end
      end
      total++;
      if (got !== 5) $display("FAIL stream_timeout: got %0d want 5 instrs", got);
      else pass_cnt++;
   endtask

   task automatic test_stall;
      bit         ok;
      exp_t       e;
      logic [7:0] d0;
      logic [1:0] p0, a0;
      apply_reset(1'b0);
      sb.push_back('{2'd0, OP_NOP});
      wait_valid(10, ok);
      total++;
      if (!ok) $display("FAIL stall_wait: got valid 0 want 1");
      else pass_cnt++;
      d0 = bus.instr_data; p0 = bus.instr_pc; a0 = bus.rom_addr;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         total++;
         if ({bus.instr_valid, bus.rom_en, bus.instr_data, bus.instr_pc, bus.rom_addr}
             !== {1'b1, 1'b0, d0, p0, a0})
            $display("FAIL stall_stable: got v%b en%b d%h pc%0d a%0d want v1 en0 d%h pc%0d a%0d",
                     bus.instr_valid, bus.rom_en, bus.instr_data, bus.instr_pc,
                     bus.rom_addr, d0, p0, a0);
         else pass_cnt++;
      end
      total++;
      if (a0 !== 2'd1) $display("FAIL stall_pc_adv: got %0d want 1", a0);
      else pass_cnt++;
      bus.instr_ready = 1'b1;
      #1;
      e = sb.pop_front();
      total++;
      if ({bus.instr_pc, bus.instr_data} !== {e.pc, e.data})
         $display("FAIL stall_deliver: got pc%0d d%h want pc%0d d%h",
                  bus.instr_pc, bus.instr_data, e.pc, e.data);
      else pass_cnt++;
      @(negedge CLK);
   endtask

   task automatic test_jump_read;
      bit   ok;
      exp_t e;
      apply_reset(1'b1);
      wait_rom_en(10, ok);
      @(negedge CLK);
      bus.jump_valid = 1'b1;
      bus.jump_addr  = 2'd2;
      @(negedge CLK);
      bus.jump_valid = 1'b0;
      total++;
      if (bus.instr_valid !== 1'b0) $display("FAIL jump_drop: got valid %b want 0", bus.instr_valid);
      else pass_cnt++;
      total++;
      if (bus.rom_addr !== 2'd2) $display("FAIL jump_pc: got %0d want 2", bus.rom_addr);
      else pass_cnt++;
      sb.push_back('{2'd2, OP_NOP1});
      wait_valid(10, ok);
      total++;
      if (!ok) $display("FAIL jump_wait: got valid 0 want 1");
      else pass_cnt++;
      e = sb.pop_front();
      total++;
      if ({bus.instr_pc, bus.instr_data} !== {e.pc, e.data})
         $display("FAIL jump_deliver: got pc%0d d%h want pc%0d d%h",
                  bus.instr_pc, bus.instr_data, e.pc, e.data);
      else pass_cnt++;
   endtask

   task automatic test_halt;
      bit   ok;
      exp_t e;
      apply_reset(1'b1);
      wait_rom_en(10, ok);
      @(negedge CLK);
      bus.halt = 1'b1;
      sb.push_back('{2'd0, OP_NOP});
      wait_valid(5, ok);
      total++;
      if (!ok) $display("FAIL halt_wait: got valid 0 want 1");
      else pass_cnt++;
      e = sb.pop_front();
      total++;
      if ({bus.instr_pc, bus.instr_data} !== {e.pc, e.data})
         $display("FAIL halt_deliver: got pc%0d d%h want pc%0d d%h",
                  bus.instr_pc, bus.instr_data, e.pc, e.data);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         total++;
         if ({bus.rom_en, bus.instr_valid} !== 2'b00)
            $display("FAIL halt_block: got en%b v%b want en0 v0", bus.rom_en, bus.instr_valid);
         else pass_cnt++;
      end
      bus.halt = 1'b0;
      #1;
      total++;
      if ({bus.rom_en, bus.rom_addr} !== {1'b1, 2'd1})
         $display("FAIL halt_resume: got en%b a%0d want en1 a1", bus.rom_en, bus.rom_addr);
      else pass_cnt++;
      @(negedge CLK);
   endtask

   task automatic test_reset_hold;
      bit   ok;
      exp_t e;
      apply_reset(1'b0);
      wait_valid(10, ok);
      total++;
      if (!ok) $display("FAIL rsthold_wait: got valid 0 want 1");
      else pass_cnt++;
      #2 RST_N = 1'b0;
      #1;
      total++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr_data} !== {1'b0, 2'd0, 8'h00})
         $display("FAIL rsthold_async: got v%b pc%0d d%h want v0 pc0 d00",
                  bus.instr_valid, bus.instr_pc, bus.instr_data);
      else pass_cnt++;
      @(negedge CLK);
      RST_N = 1'b1;
      bus.instr_ready = 1'b1;
      sb.push_back('{2'd0, OP_NOP});
      @(negedge CLK);
      total++;
      if (bus.instr_valid !== 1'b0) $display("FAIL rsthold_stale: got valid %b want 0", bus.instr_valid);
      else pass_cnt++;
      wait_valid(5, ok);
      total++;
      if (!ok) $display("FAIL rsthold_refetch: got valid 0 want 1");
      else pass_cnt++;
      e = sb.pop_front();
      total++;
      if ({bus.instr_pc, bus.instr_data} !== {e.pc, e.data})
         $display("FAIL rsthold_first: got pc%0d d%h want pc%0d d%h",
                  bus.instr_pc, bus.instr_data, e.pc, e.data);
      else pass_cnt++;
   endtask

   task automatic test_prescale;
      int q[$];
      apply_reset(1'b1);
      q.push_back(15);
      q.push_back(31);
      q.push_back(47);
      for (int c = 0; c <= 50; c++) begin
         if (c > 0) @(negedge CLK);
         if (bus.rom_en) begin
            total++;
            if (q.size() == 0) $display("FAIL prescale_extra: got rom_en at %0d want none", c);
            else if (q[0] !== c) $display("FAIL prescale_cycle: got %0d want %0d", c, q.pop_front());
            else begin
               void'(q.pop_front());
               pass_cnt++;
            end
         end
      end
      total++;
      if (q.size() !== 0) $display("FAIL prescale_missing: got %0d left want 0", q.size());
      else pass_cnt++;
   endtask

   initial begin
      rom[0] = OP_NOP;
      rom[1] = OP_LED_OFF;
      rom[2] = OP_NOP1;
      rom[3] = OP_LED_ON;
      bus.rom_data = 8'h00;
      test_reset();
`ifdef FETCH_PRESCALE_EN
      test_prescale();
`else
      test_stream();
      test_stall();
      test_jump_read();
      test_halt();
      test_reset_hold();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 ADDR_W, 2, program-counter and ROM address width.
REQ-002 DATA_W, 8, instruction width.
REQ-003 PRESCALE_W, 23, prescaler width; one fetch tick every 2^PRESCALE_W cycles.
REQ-004 CLK  input  1  single clock; all state on posedge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 rom_en  output  1  ROM read strobe, combinational.
REQ-007 rom_addr  output  ADDR_W  ROM read address, combinational, equals pc.
REQ-008 rom_data  input  DATA_W  synchronous ROM data, valid the cycle after rom_en.
REQ-009 instr_valid  output  1  instruction offered to the executor.
REQ-010 instr_ready  input  1  executor accepts the instruction.
REQ-011 instr_data  output  DATA_W  offered instruction.
REQ-012 instr_pc  output  ADDR_W  address instr_data was fetched from.
REQ-013 jump_valid  input  1  redirect request from the executor.
REQ-014 jump_addr  input  ADDR_W  redirect target.
REQ-015 halt  input  1  level; blocks new fetches.

Function
REQ-016 States SHALL be IDLE, READ and HOLD.
REQ-017 Prescaler SHALL be a free-running PRESCALE_W-bit up-counter; tick SHALL be high for the single cycle in which the count is all-ones.
REQ-018 In IDLE with tick=1, halt=0 and jump_valid=0: rom_en=1, pc <= pc+1 (mod 2^ADDR_W), fetch address saved, state -> READ.
REQ-019 In READ: instr_data <= rom_data, instr_pc <= saved address, instr_valid <= 1, state -> HOLD; tick-to-instr_valid latency is exactly 2 cycles.
REQ-020 In HOLD, instr_valid, instr_data and instr_pc SHALL stay stable until instr_valid && instr_ready; on that handshake instr_valid <= 0 and state -> IDLE.
REQ-021 Ticks arriving in READ or HOLD SHALL be dropped, never queued.
REQ-022 rom_en SHALL be 0 in every state other than the REQ-018 condition.
REQ-023 jump_valid SHALL have priority: pc <= jump_addr and state -> IDLE in any state; READ data discarded; in HOLD, instr_valid <= 0.
REQ-024 A jump in the same cycle as a HOLD handshake SHALL count the handshake as complete and still load jump_addr.
REQ-025 A jump coinciding with an IDLE tick SHALL suppress that fetch (rom_en=0).
REQ-026 halt SHALL block only new issues; READ and HOLD complete normally.
REQ-027 pc wrap from 2^ADDR_W-1 to 0 SHALL be silent.

Reset
REQ-028 RST_N low SHALL immediately force state=IDLE, pc=0, prescaler=0, instr_valid=0, instr_data=0, instr_pc=0, saved address=0; rom_en=0 follows from IDLE with prescaler 0.
REQ-029 Reset mid-READ or mid-HOLD SHALL discard the instruction; no instr_valid pulse after release until a new tick.

Configuration
REQ-030 Macro FETCH_PRESCALE_EN defined: tick per REQ-017.
REQ-031 FETCH_PRESCALE_EN undefined: tick tied to 1, prescaler removed, one fetch every 3 cycles when instr_ready is held high.

Structure
REQ-032 Shared package stack_cpu_pkg SHALL hold opcode constants (NOP 8'h00, NOP1 8'h01, LED_OFF 8'h02, LED_ON 8'h03) and the fetch state enum.
REQ-033 Prescaler SHALL be sub-module tick_gen (parameter PRESCALE_W; ports CLK, RST_N, tick).

Verification
REQ-034 FETCH_PRESCALE_EN off, ROM {00,02,01,03}, instr_ready=1 -> instr_data 00,02,01,03,00 at instr_pc 0,1,2,3,0, each 3 cycles apart.
REQ-035 instr_ready=0 for 10 cycles with instr_valid high -> instr_data/instr_pc stable, rom_en=0 throughout, no pc advance.
REQ-036 jump_valid with jump_addr=2 in READ -> ROM data dropped, next instruction delivered has instr_pc=2, instr_data=01.
REQ-037 halt=1 asserted in READ -> current instruction delivered, then rom_en stays 0 until halt=0.
REQ-038 RST_N low during HOLD -> instr_valid=0 without waiting for CLK; after release first instr_pc=0.
REQ-039 FETCH_PRESCALE_EN on, PRESCALE_W=4 -> rom_en pulses at cycles 15, 31, 47 after reset release when instr_ready=1.
